score_event_ctrl: RTL

- Drives the Inc/Dec/LD control side of the 4-bit up/down score counter.
- Takes raw asynchronous game events (hit, miss, clear) and synchronises, debounces and edge-detects them.
- Arbitrates the events and emits single-cycle, mutually exclusive inc/dec/load pulses.
- Keeps a shadow copy of the score so it never drives the counter past 0 or MAX_SCORE, and flags a win.

---
 rtl/score_event_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/score_event_ctrl.sv
// score_event_ctrl: control side of the 4-bit up/down score counter.
// Raw hit/miss/clear events are synchronised, debounced and edge-detected,
// then arbitrated into single-cycle inc/dec/load pulses. A shadow copy of
// the score keeps the counter inside 0..MAX_SCORE and flags a win.
module score_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_SCORE       = 15,
  parameter int WIN_SCORE       = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_in,
  input  logic       miss_in,
  input  logic       clear_in,
  output logic       inc_o,
  output logic       dec_o,
  output logic       ld_o,
  output logic [3:0] shadow_q,
  output logic       win_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2
  } state_t;

  // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1 before
  // the level flips on the following stable sample.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_Q   = 4'(MAX_SCORE);
  localparam logic [3:0] WIN_Q   = 4'(WIN_SCORE);

  // Bit 0 = hit, bit 1 = miss, bit 2 = clear; all three paths are identical.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_d;
  logic [7:0] db_cnt [3];
  logic [2:0] rise;
  state_t     state;

  assign raw     = {clear_in, miss_in, hit_in};
  assign rise    = deb & ~deb_d;
  assign state_o = state;

  // Synchronise, debounce and delay each raw input so rising edges of the debounced level can be seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Arbitrate events into registered, mutually exclusive pulses and track the shadow score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      inc_o    <= 1'b0;
      dec_o    <= 1'b0;
      ld_o     <= 1'b0;
      shadow_q <= '0;
      win_o    <= 1'b0;
    end else begin
      inc_o <= 1'b0;
      dec_o <= 1'b0;
      ld_o  <= 1'b0;
      case (state)
        INIT: begin
          ld_o     <= 1'b1;
          shadow_q <= '0;
          win_o    <= 1'b0;
          state    <= PLAY;
        end
        PLAY: begin
          if (rise[2]) begin
            ld_o     <= 1'b1;
            shadow_q <= '0;
          end else if (rise[0] && rise[1]) begin
            // Simultaneous hit and miss cancel each other out.
          end else if (rise[0]) begin
            if (shadow_q < MAX_Q) begin
              inc_o    <= 1'b1;
              shadow_q <= shadow_q + 4'd1;
              if ((shadow_q + 4'd1) == WIN_Q) begin
                state <= WON;
                win_o <= 1'b1;
              end
            end
          end else if (rise[1]) begin
            if (shadow_q != 4'd0) begin
              dec_o    <= 1'b1;
              shadow_q <= shadow_q - 4'd1;
            end
          end
        end
        WON: begin
          if (rise[2]) begin
            ld_o     <= 1'b1;
            shadow_q <= '0;
            win_o    <= 1'b0;
            state    <= PLAY;
          end
        end
        default: begin
          state <= INIT;
          win_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
